// File: rtl/regfile_pkg.sv
// Shared widths, source identifiers and the buffered writeback entry type
// for the register-file writeback path.
package regfile_pkg;
   localparam int REGISTER_WIDTH = 32;
   localparam int REG_ADDR_WIDTH = 5;
   localparam int NUM_REGS       = 2**REG_ADDR_WIDTH;

   localparam logic SRC_ALU = 1'b0;
   localparam logic SRC_LSU = 1'b1;

   typedef struct packed {
      logic                      valid;
      logic [REG_ADDR_WIDTH-1:0] rd;
      logic [REGISTER_WIDTH-1:0] data;
   } wb_entry_t;
endpackage

// File: rtl/wb_slot.sv
// One-entry writeback buffer: accepts from one producer, is drained by the
// arbiter grant, and may drain and reload on the same edge.
module wb_slot
   import regfile_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   input  logic [REG_ADDR_WIDTH-1:0] in_rd,
   input  logic [REGISTER_WIDTH-1:0] in_data,
   input  logic                      grant,
   output logic                      ready,
   output logic                      load,
   output wb_entry_t                 entry
);
   assign ready = !entry.valid | grant;

   // Writes to x0 complete the handshake but are dropped here.
   assign load = in_valid & ready & (in_rd != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         entry <= '0;
      end else if (load) begin
         // NOTE: non-blocking assignments for all clocked state so every
         // flop samples pre-edge values regardless of block ordering.
         entry <= '{valid: 1'b1, rd: in_rd, data: in_data};
      end else if (grant) begin
         entry.valid <= 1'b0;
      end
   end
endmodule

// File: rtl/regfile_writeback.sv
// Writeback initiator: buffers ALU and LSU results, arbitrates oldest-first
// with round-robin tie-break, and drives a registered regfile write port.
module regfile_writeback #(
   parameter int REGISTER_WIDTH = regfile_pkg::REGISTER_WIDTH,
   parameter int REG_ADDR_WIDTH = regfile_pkg::REG_ADDR_WIDTH
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic                         alu_valid,
   output logic                         alu_ready,
   input  logic [REG_ADDR_WIDTH-1:0]    alu_rd,
   input  logic [REGISTER_WIDTH-1:0]    alu_data,
   input  logic                         lsu_valid,
   output logic                         lsu_ready,
   input  logic [REG_ADDR_WIDTH-1:0]    lsu_rd,
   input  logic [REGISTER_WIDTH-1:0]    lsu_data,
   output logic                         rf_we,
   output logic [REG_ADDR_WIDTH-1:0]    rf_rd_addr,
   output logic [REGISTER_WIDTH-1:0]    rf_rd_data,
   output logic [2**REG_ADDR_WIDTH-1:0] pending_mask,
   output logic                         idle
);
   import regfile_pkg::*;

   wb_entry_t slot0, slot1, out_q;
   logic      load0, load1, grant0, grant1;
   logic      older0, older1, rr_ptr, tie, stay0, stay1;

   wb_slot u_slot0 (
      .clk(clk), .rst(rst), .in_valid(alu_valid), .in_rd(alu_rd), .in_data(alu_data),
      .grant(grant0), .ready(alu_ready), .load(load0), .entry(slot0)
   );

   wb_slot u_slot1 (
      .clk(clk), .rst(rst), .in_valid(lsu_valid), .in_rd(lsu_rd), .in_data(lsu_data),
      .grant(grant1), .ready(lsu_ready), .load(load1), .entry(slot1)
   );

   always_comb begin
      // NOTE: defaults first so every path assigns every output; no latches.
      grant0 = 1'b0;
      grant1 = 1'b0;
      tie    = slot0.valid & slot1.valid & (older0 == older1);
      if (start) begin
         if (slot0.valid & slot1.valid) begin
            if (tie) begin
               grant0 = (rr_ptr == SRC_ALU);
               grant1 = (rr_ptr == SRC_LSU);
            end else begin
               grant0 = older0;
               grant1 = older1;
            end
         end else begin
            grant0 = slot0.valid;
            grant1 = slot1.valid;
         end
      end
   end

   assign stay0 = slot0.valid & !grant0;
   assign stay1 = slot1.valid & !grant1;

   // A slot becomes "older" only when it stays full while the other one loads.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         older0 <= 1'b0;
         older1 <= 1'b0;
         rr_ptr <= SRC_ALU;
      end else begin
         older0 <= !load0 & stay0 & (load1 | older0);
         older1 <= !load1 & stay1 & (load0 | older1);
         if (start & tie) rr_ptr <= ~rr_ptr;
      end
   end

   // With start low the output stage freezes so a pending write is not lost.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q <= '0;
      end else if (start) begin
         if (grant0)      out_q <= slot0;
         else if (grant1) out_q <= slot1;
         else             out_q.valid <= 1'b0;
      end
   end

   assign rf_we      = out_q.valid;
   assign rf_rd_addr = out_q.rd;
   assign rf_rd_data = out_q.data;

   always_comb begin
      pending_mask = '0;
      if (slot0.valid) pending_mask[slot0.rd] = 1'b1;
      if (slot1.valid) pending_mask[slot1.rd] = 1'b1;
      if (out_q.valid) pending_mask[out_q.rd] = 1'b1;
   end

   assign idle = !slot0.valid & !slot1.valid & !out_q.valid;
endmodule
